// File: rtl/rainbow_sequencer.sv
// Hue-wheel sequencer. It steps a six-phase RGB colour wheel on each
// end-of-fade edge, and it drives a 2-bit rise/fall/hold command per
// channel. A per-phase watchdog forces the wheel forward when a fade
// stage never reports completion.
module rainbow_sequencer #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd750000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       fade_done,
   output logic [1:0] r_mode,
   output logic [1:0] g_mode,
   output logic [1:0] b_mode,
   output logic [2:0] phase,
   output logic       busy,
   output logic       cycle_done,
   output logic       stall
);

   // Phase states use their wheel index as the encoding, so the phase output is the state itself.
   typedef enum logic [2:0] {
      S_P0   = 3'd0,
      S_P1   = 3'd1,
      S_P2   = 3'd2,
      S_P3   = 3'd3,
      S_P4   = 3'd4,
      S_P5   = 3'd5,
      S_IDLE = 3'd6
   } state_t;

   localparam logic [1:0] M_OFF  = 2'b00;
   localparam logic [1:0] M_RISE = 2'b01;
   localparam logic [1:0] M_FALL = 2'b10;
   localparam logic [1:0] M_ON   = 2'b11;

   state_t      r_state;
   state_t      w_next;
   logic        r_fd_q;
   logic        r_fd_q2;
   logic [31:0] r_wdog;
   logic        w_adv_edge;
   logic        w_busy;
   logic        w_expire;
   logic        w_adv;
   logic        w_wrap;
   logic        w_stall;

   // Concatenated {r, g, b} channel commands for a state.
   function automatic logic [5:0] mode_decode(input state_t s);
      logic [5:0] m;
      case (s)
         S_P0:    m = {M_ON,   M_RISE, M_OFF };
         S_P1:    m = {M_FALL, M_ON,   M_OFF };
         S_P2:    m = {M_OFF,  M_ON,   M_RISE};
         S_P3:    m = {M_OFF,  M_FALL, M_ON  };
         S_P4:    m = {M_RISE, M_OFF,  M_ON  };
         S_P5:    m = {M_ON,   M_OFF,  M_FALL};
         default: m = {M_OFF,  M_OFF,  M_OFF };
      endcase
      return m;
   endfunction

   // Next phase around the wheel, wrapping P5 back to P0.
   function automatic state_t next_phase(input state_t s);
      state_t n;
      case (s)
         S_P0:    n = S_P1;
         S_P1:    n = S_P2;
         S_P2:    n = S_P3;
         S_P3:    n = S_P4;
         S_P4:    n = S_P5;
         default: n = S_P0;
      endcase
      return n;
   endfunction

   assign w_adv_edge = r_fd_q & ~r_fd_q2;
   assign w_busy     = (r_state != S_IDLE);
   assign w_expire   = w_busy && (r_wdog == (TIMEOUT_CYCLES - 32'd1));
   assign w_adv      = w_busy && (w_adv_edge || w_expire);

   // fade_done history runs every cycle so a level already high at start never looks like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fd_q  <= 1'b0;
         r_fd_q2 <= 1'b0;
      end else begin
         r_fd_q  <= fade_done;
         r_fd_q2 <= r_fd_q;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and pulse qualifiers; stop outranks both start and any advance.
   always_comb begin
      w_next  = r_state;
      w_wrap  = 1'b0;
      w_stall = 1'b0;
      if (r_state == S_IDLE) begin
         if (start && !stop) begin
            w_next = S_P0;
         end
      end else if (stop) begin
         w_next = S_IDLE;
      end else if (w_adv) begin
         w_next  = next_phase(r_state);
         w_wrap  = (r_state == S_P5);
         w_stall = w_expire && !w_adv_edge;
      end
   end

   // Watchdog restarts on every state change and idles at zero outside the wheel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog <= 32'd0;
      end else if (!w_busy || (w_next != r_state)) begin
         r_wdog <= 32'd0;
      end else begin
         r_wdog <= r_wdog + 32'd1;
      end
   end

   // Registered outputs decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         {r_mode, g_mode, b_mode} <= 6'd0;
         phase      <= 3'd0;
         busy       <= 1'b0;
         cycle_done <= 1'b0;
         stall      <= 1'b0;
      end else begin
         {r_mode, g_mode, b_mode} <= mode_decode(w_next);
         phase      <= (w_next == S_IDLE) ? 3'd0 : 3'(w_next);
         busy       <= (w_next != S_IDLE);
         cycle_done <= w_wrap;
         stall      <= w_stall;
      end
   end

endmodule

// File: tb/tb_rainbow_sequencer.sv
// Directed bench for rainbow_sequencer: reset defaults, full wheel,
// held fade_done level, watchdog expiry, priority and reset mid-phase.
module tb_rainbow_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       fade_done;
   logic [1:0] r_mode;
   logic [1:0] g_mode;
   logic [1:0] b_mode;
   logic [2:0] phase;
   logic       busy;
   logic       cycle_done;
   logic       stall;

   int n_cmp = 0;
   int n_err = 0;

   rainbow_sequencer #(.TIMEOUT_CYCLES(32'd16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .fade_done  (fade_done),
      .r_mode     (r_mode),
      .g_mode     (g_mode),
      .b_mode     (b_mode),
      .phase      (phase),
      .busy       (busy),
      .cycle_done (cycle_done),
      .stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {r,g,b,phase,busy,cycle_done,stall}; ph < 0 means IDLE.
   function automatic logic [11:0] expv(input int ph, input logic cd, input logic st);
      logic [5:0] m;
      case (ph)
         0:       m = 6'b11_01_00;
         1:       m = 6'b10_11_00;
         2:       m = 6'b00_11_01;
         3:       m = 6'b00_10_11;
         4:       m = 6'b01_00_11;
         5:       m = 6'b11_00_10;
         default: m = 6'b00_00_00;
      endcase
      if (ph < 0) return {m, 3'd0, 1'b0, cd, st};
      return {m, 3'(ph), 1'b1, cd, st};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [11:0] exp);
      logic [11:0] obs;
      obs = {r_mode, g_mode, b_mode, phase, busy, cycle_done, stall};
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One fade_done rise: new phase visible two edges after the input goes high.
   task automatic advance(input string tag, input int ph_after);
      fade_done = 1'b1;
      tick();
      tick();
      check(tag, expv(ph_after, 1'b0, 1'b0));
      fade_done = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; fade_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset defaults
      check("reset", expv(-1, 1'b0, 1'b0));
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_hold", expv(-1, 1'b0, 1'b0));
      end

      // Full wheel: 4 cycles high, 8 low per fade (period below the 16-cycle watchdog)
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_p0", expv(0, 1'b0, 1'b0));
      for (int n = 0; n < 6; n++) begin
         fade_done = 1'b1;
         tick();
         check("wheel_lat1", expv(n, 1'b0, 1'b0));
         tick();
         check("wheel_adv", expv((n + 1) % 6, (n == 5), 1'b0));
         tick();
         check("wheel_pulse_end", expv((n + 1) % 6, 1'b0, 1'b0));
         tick();
         fade_done = 1'b0;
         for (int j = 0; j < 8; j++) tick();
         check("wheel_low", expv((n + 1) % 6, 1'b0, 1'b0));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_p0", expv(-1, 1'b0, 1'b0));

      // Held level: fade_done high before start does not advance P0
      fade_done = 1'b1;
      tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("held_p0", expv(0, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++) begin
         tick();
         check("held_stay", expv(0, 1'b0, 1'b0));
      end
      fade_done = 1'b0;
      tick(); tick();
      fade_done = 1'b1;
      tick();
      check("held_rerise_lat", expv(0, 1'b0, 1'b0));
      tick();
      check("held_rerise_adv", expv(1, 1'b0, 1'b0));
      fade_done = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("held_stop", expv(-1, 1'b0, 1'b0));
      tick(); tick();

      // Watchdog: forced advance 16 clocks after P0 entry
      start = 1'b1;
      tick();
      start = 1'b0;
      check("wd_p0", expv(0, 1'b0, 1'b0));
      for (int i = 1; i < 16; i++) begin
         tick();
         check("wd_wait", expv(0, 1'b0, 1'b0));
      end
      tick();
      check("wd_expire", expv(1, 1'b0, 1'b1));
      tick();
      check("wd_stall_end", expv(1, 1'b0, 1'b0));
      for (int i = 2; i < 15; i++) begin
         tick();
         check("wd_wait2", expv(1, 1'b0, 1'b0));
      end
      // Edge lands on the same cycle the counter hits 15: one advance, no stall
      fade_done = 1'b1;
      tick();
      check("wd_coinc_lat", expv(1, 1'b0, 1'b0));
      tick();
      check("wd_coinc_adv", expv(2, 1'b0, 1'b0));
      tick();
      check("wd_coinc_single", expv(2, 1'b0, 1'b0));
      fade_done = 1'b0;
      tick();
      tick();

      // Priority: stop with an edge in P3 returns to IDLE
      advance("to_p3", 3);
      fade_done = 1'b1;
      tick();
      check("prio_lat", expv(3, 1'b0, 1'b0));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      fade_done = 1'b0;
      check("prio_stop_edge", expv(-1, 1'b0, 1'b0));
      tick();
      check("prio_idle", expv(-1, 1'b0, 1'b0));
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      check("prio_start_stop", expv(-1, 1'b0, 1'b0));
      tick();
      check("prio_idle2", expv(-1, 1'b0, 1'b0));

      // Reset mid-phase in P4
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rst_p0", expv(0, 1'b0, 1'b0));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy_ignored", expv(0, 1'b0, 1'b0));
      advance("rst_to_p1", 1);
      advance("rst_to_p2", 2);
      advance("rst_to_p3", 3);
      advance("rst_to_p4", 4);
      rst = 1'b1;
      tick();
      check("rst_mid", expv(-1, 1'b0, 1'b0));
      rst = 1'b0;
      tick();
      check("rst_after", expv(-1, 1'b0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
